t_pulse_debounce: RTL
=====================

// Module: t_pulse_debounce
// PURPOSE
//   Upstream stage for the toggle flip-flop: turns a raw, bouncing, asynchronous
//   push-button input into a clean single-cycle toggle-enable pulse on t.
//   Chain: btn_in -> 2-FF synchronizer -> debounce FSM -> t -> T flip-flop.
//   One debounced press yields exactly one toggle of the downstream flip-flop.
// PARAMETERS
//   DEBOUNCE_CYCLES   16  consecutive stable synced cycles required to accept a level change (>=2)
//   CNT_W             5   debounce counter width; must satisfy DEBOUNCE_CYCLES <= 2**CNT_W
//   PULSE_ON_RELEASE  0   1 = also emit a t pulse on the accepted release
// PORTS
//   clk     in   1  single system clock, rising edge
//   rst_n   in   1  asynchronous, active-low reset
//   btn_in  in   1  raw button, asynchronous to clk, may bounce
//   t       out  1  registered single-cycle toggle-enable pulse to the T flip-flop
//   level   out  1  registered debounced button level
//   busy    out  1  1 while a level change is being qualified (CHK_* states)
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync regs=0, state=IDLE_LOW, cnt=0, t=0, level=0, busy=0.
//     Release of rst_n takes effect on the next clk edge; no pulse is generated on reset exit.
//   - Synchronizer: btn_s = 2nd stage of a 2-FF chain on btn_in; the FSM sees only btn_s.
//   - States: IDLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW.
//     IDLE_LOW:    btn_s=1 -> CHK_HIGH, cnt<=0.
//     CHK_HIGH:    btn_s=0 -> IDLE_LOW, cnt<=0 (bounce rejected, no pulse);
//                  btn_s=1 & cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level<=1, t<=1;
//                  otherwise cnt<=cnt+1.
//     STABLE_HIGH: btn_s=0 -> CHK_LOW, cnt<=0.
//     CHK_LOW:     btn_s=1 -> STABLE_HIGH, cnt<=0;
//                  btn_s=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE_LOW, level<=0, t<=PULSE_ON_RELEASE;
//                  otherwise cnt<=cnt+1.
//   - t is high for exactly one cycle per accepted edge. It returns to 0 on the following edge,
//     regardless of btn_s.
//   - Latency: number the first clk edge that samples btn_in high as edge 1. With the input
//     stable from then on, t and level rise on edge DEBOUNCE_CYCLES+3 (edge 19 at default).
//     Release is symmetric for level.
//   - busy = (state==CHK_HIGH || state==CHK_LOW), registered alongside state.
//   - cnt never wraps: it saturates its use at DEBOUNCE_CYCLES-1, where the transition fires.
//   - A glitch shorter than 2 clk cycles may be missed by the synchronizer; this is acceptable.
//   - Reset mid-qualification aborts it: no pulse is emitted and the FSM restarts from IDLE_LOW.
//   - A press held indefinitely yields one pulse only; a new pulse requires an accepted release.
// STRUCTURE
//   - Shared package: state encoding constants (2-bit: IDLE_LOW=0, CHK_HIGH=1,
//     STABLE_HIGH=2, CHK_LOW=3).
//   - Sub-module sync_2ff: 2-stage synchronizer with async active-low reset to 0.
//   - Top: FSM, counter and output registers.
// TESTING (DEBOUNCE_CYCLES=16 unless noted)
//   1. Clean press: btn_in 0->1, held 40 cycles -> t=1 on edge 19 only; level=1 from edge 19;
//      busy=1 during edges 3..18.
//   2. Bounce: btn_in high 5 cycles / low 1 cycle, repeated 10 times, then low
//      -> t never 1, level stays 0.
//   3. Release, PULSE_ON_RELEASE=0: after test 1, btn_in 1->0 -> level=0 on edge 19, t stays 0.
//      Repeat with PULSE_ON_RELEASE=1 -> one t pulse on edge 19.
//   4. Reset mid-operation: assert rst_n=0 at edge 10 of a press -> t, level, busy go 0
//      immediately; no pulse after rst_n=1 until a fresh 16-cycle qualification completes.
//   5. Long hold: btn_in high 1000 cycles -> exactly one t pulse.
//   6. Integration: t drives the T flip-flop with q initialised to 0; three clean press/release
//      cycles -> q toggles 0->1->0->1, one toggle per press.

Source files
------------

// File: rtl/t_pulse_debounce_pkg.sv
// Shared definitions for the push-button debounce front end of the toggle flip-flop.
// State encoding is fixed so it can be observed and compared against other tools directly.
package t_pulse_debounce_pkg;

  typedef enum logic [1:0] {
    IdleLow    = 2'd0,
    ChkHigh    = 2'd1,
    StableHigh = 2'd2,
    ChkLow     = 2'd3
  } state_e;

endpackage

// File: rtl/t_pulse_debounce_sync_2ff.sv
// Two-stage synchronizer that brings the raw button into the clk domain.
// Both stages clear to 0 on the asynchronous active-low reset.
module t_pulse_debounce_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/t_pulse_debounce.sv
// Debounces a raw push-button and emits one single-cycle toggle-enable pulse on t per
// accepted press (and optionally per accepted release).
module t_pulse_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned CNT_W            = 5,
  parameter bit          PULSE_ON_RELEASE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic t,
  output logic level,
  output logic busy
);

  import t_pulse_debounce_pkg::*;

  // The qualifying transition fires on this count, so the counter never wraps.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_q, t_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;

  t_pulse_debounce_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IdleLow;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    t_d     = 1'b0;
    case (state_q)
      IdleLow: begin
        if (btn_s) begin
          state_d = ChkHigh;
          cnt_d   = '0;
        end
      end
      ChkHigh: begin
        if (!btn_s) begin
          state_d = IdleLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StableHigh;
          level_d = 1'b1;
          t_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StableHigh: begin
        if (!btn_s) begin
          state_d = ChkLow;
          cnt_d   = '0;
        end
      end
      ChkLow: begin
        if (btn_s) begin
          state_d = StableHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IdleLow;
          level_d = 1'b0;
          t_d     = PULSE_ON_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IdleLow;
        cnt_d   = '0;
      end
    endcase
    // Registered alongside state so busy lines up with the CHK_* states exactly.
    busy_d = (state_d == ChkHigh) || (state_d == ChkLow);
  end

  assign t     = t_q;
  assign level = level_q;
  assign busy  = busy_q;

endmodule
